// File: rtl/viterbi_seq_ctl_if.sv
// Upstream code-symbol handshake into the Viterbi symbol sequencer.
interface viterbi_seq_ctl_if #(
    parameter int WD_CODE = 2
);
    logic               InValid;
    logic [WD_CODE-1:0] InCode;
    logic               InReady;

    modport master (output InValid, output InCode, input InReady);
    modport slave  (input InValid, input InCode, output InReady);
endinterface

// File: rtl/viterbi_seq_ctl.sv
// Symbol-level sequencer: holds one code symbol, sweeps the 2^WD_FSM ACS
// segments per symbol, and advances survivor pages / traceback requests.
module viterbi_seq_ctl #(
    parameter int WD_FSM   = 6,
    parameter int WD_CODE  = 2,
    parameter int WD_PAGE  = 5,
    parameter int TB_DEPTH = 32
) (
    input  logic               Clock2,
    input  logic               Reset,
    viterbi_seq_ctl_if.slave   symIn,
    output logic [WD_CODE-1:0] Code,
    output logic [WD_FSM-1:0]  ACSSegment,
    output logic               ACSEnable,
    output logic [WD_PAGE-1:0] ACSPage,
    output logic               SymbolDone,
    output logic               TBStart,
    output logic [WD_PAGE-1:0] TBPage,
    output logic               Busy
);
    localparam int                WD_CNT   = $clog2(TB_DEPTH + 1);
    localparam logic [WD_FSM-1:0] SEG_LAST = '1;
    localparam logic [WD_CNT-1:0] CNT_MAX  = WD_CNT'(TB_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, stateNext;
    logic              codeValid;
    logic              segLast;
    logic              accept;
    logic              consume;
    logic              endEdge;
    logic [WD_CNT-1:0] symbolCount;

    assign segLast       = (ACSSegment == SEG_LAST);
    assign symIn.InReady = ~codeValid;
    assign accept        = symIn.InValid & ~codeValid;
    assign consume       = segLast & codeValid & ((state == IDLE) | ACSEnable);
    assign endEdge       = (state == RUN) & segLast;
    assign ACSEnable     = (state == RUN);
    assign Busy          = (state == RUN) | codeValid;

    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (consume) stateNext = RUN;
            RUN:     if (endEdge && !consume) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Wrapping from all-ones to zero doubles as the restart for a consumed symbol.
    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            ACSSegment <= SEG_LAST;
        end else if (consume || (ACSEnable && !segLast)) begin
            ACSSegment <= ACSSegment + WD_FSM'(1);
        end
    end

    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            Code      <= '0;
            codeValid <= 1'b0;
        end else if (accept) begin
            Code      <= symIn.InCode;
            codeValid <= 1'b1;
        end else if (consume) begin
            codeValid <= 1'b0;
        end
    end

    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            ACSPage     <= '0;
            TBPage      <= '0;
            symbolCount <= '0;
            SymbolDone  <= 1'b0;
            TBStart     <= 1'b0;
        end else begin
            SymbolDone <= endEdge;
            // Post-increment count reaching TB_DEPTH means the pre-increment one is TB_DEPTH-1.
            TBStart    <= endEdge && (symbolCount >= CNT_MAX - WD_CNT'(1));
            if (endEdge) begin
                ACSPage <= ACSPage + WD_PAGE'(1);
                TBPage  <= ACSPage;
                if (symbolCount != CNT_MAX) begin
                    symbolCount <= symbolCount + WD_CNT'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_seq_ctl.sv
// Scoreboard bench for viterbi_seq_ctl: accepted codes are queued and checked
// when their symbol starts; page/traceback outputs checked against a symbol model.
`timescale 1ns/1ps
module tb_viterbi_seq_ctl;
    localparam int WD_FSM    = 6;
    localparam int WD_CODE   = 2;
    localparam int WD_PAGE   = 5;
    localparam int TB_DEPTH  = 32;
    localparam int SEG_COUNT = 1 << WD_FSM;
    localparam int SEG_LAST  = SEG_COUNT - 1;
    localparam int PAGES     = 1 << WD_PAGE;
    localparam int STREAM_N  = 40;

    logic               Clock2 = 1'b0;
    logic               Reset  = 1'b0;
    logic [WD_CODE-1:0] Code;
    logic [WD_FSM-1:0]  ACSSegment;
    logic               ACSEnable;
    logic [WD_PAGE-1:0] ACSPage;
    logic               SymbolDone;
    logic               TBStart;
    logic [WD_PAGE-1:0] TBPage;
    logic               Busy;

    viterbi_seq_ctl_if #(.WD_CODE(WD_CODE)) symIf ();

    viterbi_seq_ctl #(
        .WD_FSM(WD_FSM), .WD_CODE(WD_CODE), .WD_PAGE(WD_PAGE), .TB_DEPTH(TB_DEPTH)
    ) dut (
        .Clock2(Clock2), .Reset(Reset), .symIn(symIf),
        .Code(Code), .ACSSegment(ACSSegment), .ACSEnable(ACSEnable),
        .ACSPage(ACSPage), .SymbolDone(SymbolDone), .TBStart(TBStart),
        .TBPage(TBPage), .Busy(Busy)
    );

    always #5 Clock2 = ~Clock2;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    logic [WD_CODE-1:0] codeQueue[$];
    int                 cyc         = 0;
    int                 doneCount   = 0;
    int                 lastDoneCyc = -1;
    int                 enStartCyc  = -1;
    int                 enableCount = 0;
    int                 readyFalls  = 0;
    logic               prevEnable  = 1'b0;
    logic               prevReady   = 1'b1;
    logic [WD_FSM-1:0]  prevSeg     = '1;
    logic [WD_CODE-1:0] lastCode    = '0;

    // Posedge: count cycles and capture accepts. Negedge: check against the model.
    always @(posedge Clock2 or negedge Clock2) begin
        if (Clock2) begin
            cyc++;
            if (Reset && symIf.InValid && symIf.InReady) codeQueue.push_back(symIf.InCode);
        end else if (!Reset) begin
            doneCount  = 0;
            codeQueue.delete();
            prevEnable = 1'b0;
            prevReady  = 1'b1;
        end else begin
            if (ACSEnable) begin
                enableCount++;
                if (!prevEnable) enStartCyc = cyc;
                if (prevEnable && prevSeg != WD_FSM'(SEG_LAST))
                    checkValue("segStep", ACSSegment, 32'(prevSeg) + 1);
                if (ACSSegment == '0) begin
                    checkValue("sbPending", codeQueue.size() != 0, 1);
                    if (codeQueue.size() != 0) checkValue("sbCode", Code, codeQueue.pop_front());
                end
            end
            if (SymbolDone) begin
                doneCount++;
                lastDoneCyc = cyc;
                checkValue("acsPage", ACSPage, doneCount % PAGES);
                checkValue("tbPage", TBPage, (doneCount - 1) % PAGES);
                checkValue("tbStart", TBStart, doneCount >= TB_DEPTH);
            end else begin
                checkValue("tbIdle", TBStart, 0);
            end
            if (prevReady && !symIf.InReady) readyFalls++;
            prevReady  = symIf.InReady;
            prevEnable = ACSEnable;
            prevSeg    = ACSSegment;
        end
    end

    task automatic sendSymbol(input logic [WD_CODE-1:0] c, output int acceptCyc);
        bit done = 1'b0;
        acceptCyc = -1;
        @(negedge Clock2);
        symIf.InValid = 1'b1;
        symIf.InCode  = c;
        for (int n = 0; n < 4 * SEG_COUNT && !done; n++) begin
            if (symIf.InReady) begin
                @(posedge Clock2);
                #1;
                symIf.InValid = 1'b0;
                acceptCyc     = cyc;
                lastCode      = c;
                done          = 1'b1;
            end else begin
                checkValue("codeHold", Code, lastCode);
                @(negedge Clock2);
            end
        end
        if (!done) begin
            checkValue("acceptTimeout", done, 1);
            symIf.InValid = 1'b0;
        end
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (doneCount < target && n < budget) begin
            @(negedge Clock2);
            #1;
            n++;
        end
        checkValue("doneReached", doneCount >= target, 1);
    endtask

    task automatic waitSegment(input int seg, input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge Clock2);
            if (ACSEnable && ACSSegment == WD_FSM'(seg)) found = 1'b1;
        end
        checkValue("segWait", found, 1);
    endtask

    task automatic checkResetValues();
        checkValue("rstSegment", ACSSegment, SEG_LAST);
        checkValue("rstEnable", ACSEnable, 0);
        checkValue("rstCode", Code, 0);
        checkValue("rstPage", ACSPage, 0);
        checkValue("rstDone", SymbolDone, 0);
        checkValue("rstTbStart", TBStart, 0);
        checkValue("rstTbPage", TBPage, 0);
        checkValue("rstBusy", Busy, 0);
        checkValue("rstReady", symIf.InReady, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passCount, checkCount);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a0, en0, rf0, d0;
        symIf.InValid = 1'b0;
        symIf.InCode  = '0;
        repeat (3) @(negedge Clock2);
        #1;
        checkResetValues();
        @(negedge Clock2);
        #2 Reset = 1'b1;

        // Single symbol from idle.
        en0 = enableCount;
        sendSymbol(2'b10, a);
        waitDone(1, 4 * SEG_COUNT);
        checkValue("singleEnStart", enStartCyc, a + 1);
        checkValue("singleDoneCyc", lastDoneCyc, a + 1 + SEG_COUNT);
        checkValue("singleEnCount", enableCount - en0, SEG_COUNT);
        repeat (3) @(negedge Clock2);
        checkValue("singleHoldSeg", ACSSegment, SEG_LAST);
        checkValue("singleHoldEn", ACSEnable, 0);
        checkValue("singleBusy", Busy, 0);
        checkValue("singlePage", ACSPage, 1);

        // Back-to-back stream crossing TB_DEPTH and the page wrap.
        en0 = enableCount;
        rf0 = readyFalls;
        d0  = doneCount;
        a0  = -1;
        for (int i = 0; i < STREAM_N; i++) begin
            sendSymbol(WD_CODE'($urandom_range(0, 3)), a);
            if (i == 0) a0 = a;
        end
        waitDone(d0 + STREAM_N, 4 * SEG_COUNT);
        checkValue("streamDoneCyc", lastDoneCyc, a0 + 1 + STREAM_N * SEG_COUNT);
        checkValue("streamEnCount", enableCount - en0, STREAM_N * SEG_COUNT);
        checkValue("streamReadyFalls", readyFalls - rf0, STREAM_N);
        repeat (3) @(negedge Clock2);

        // Accept landing on the end edge: one idle cycle, then restart.
        d0 = doneCount;
        sendSymbol(2'b11, a);
        waitSegment(SEG_LAST, 4 * SEG_COUNT);
        symIf.InValid = 1'b1;
        symIf.InCode  = 2'b01;
        @(posedge Clock2);
        #1;
        symIf.InValid = 1'b0;
        lastCode      = 2'b01;
        @(negedge Clock2);
        checkValue("gapEnable", ACSEnable, 0);
        checkValue("gapSegment", ACSSegment, SEG_LAST);
        checkValue("gapBusy", Busy, 1);
        @(negedge Clock2);
        checkValue("restartEnable", ACSEnable, 1);
        checkValue("restartSegment", ACSSegment, 0);
        waitDone(d0 + 2, 4 * SEG_COUNT);

        // Asynchronous reset mid-symbol with another symbol pending.
        sendSymbol(2'b01, a);
        sendSymbol(2'b10, a);
        waitSegment(32, 4 * SEG_COUNT);
        #2 Reset = 1'b0;
        #1;
        checkResetValues();
        repeat (2) @(negedge Clock2);
        #2 Reset = 1'b1;
        en0 = enableCount;
        repeat (100) @(negedge Clock2);
        #1;
        checkValue("noStaleSymbol", enableCount - en0, 0);
        checkValue("noStaleBusy", Busy, 0);
        sendSymbol(2'b11, a);
        waitDone(1, 4 * SEG_COUNT);
        checkValue("postResetPage", ACSPage, 1);
        repeat (3) @(negedge Clock2);
        checkValue("sbDrained", codeQueue.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/viterbi_seq_ctl.md
Name: viterbi_seq_ctl

Overview:
- Symbol-level sequencer for the hard-decision Viterbi decoder.
- Accepts received 2-bit code symbols over a valid/ready handshake and presents each one on Code for the branch-metric unit.
- Steps ACSSegment 0..63 once per symbol; the branch-metric unit and ACS array time-share their 8-branch datapath across those 64 segments.
- Advances the survivor-memory page pointer and issues traceback start pulses once the trellis is deep enough.

Parameters:
- WD_FSM, 6, segment counter width; a symbol takes 2^WD_FSM cycles.
- WD_CODE, 2, code symbol width.
- WD_PAGE, 5, survivor page pointer width; 2^WD_PAGE pages.
- TB_DEPTH, 32, symbols completed before the first TBStart. Legal range 1..2^WD_PAGE.

Ports:
- Clock2, in, 1, decoder clock; all state updates on the rising edge.
- Reset, in, 1, asynchronous, active-low.
- InValid, in, 1, upstream symbol valid.
- InCode, in, WD_CODE, upstream symbol.
- InReady, out, 1, symbol accepted on an edge with InValid & InReady.
- Code, out, WD_CODE, next symbol; the branch-metric unit samples it on an edge where ACSSegment == all-ones.
- ACSSegment, out, WD_FSM, current segment.
- ACSEnable, out, 1, the current segment is real ACS work.
- ACSPage, out, WD_PAGE, survivor page written by the current symbol.
- SymbolDone, out, 1, one-cycle pulse after each symbol completes.
- TBStart, out, 1, one-cycle pulse requesting traceback.
- TBPage, out, WD_PAGE, page of the just-completed symbol; valid with TBStart.
- Busy, out, 1, RUN state or a symbol pending.

Behaviour:
- Reset values: ACSSegment = all-ones, ACSEnable = 0, Code = 0, CodeValid = 0, ACSPage = 0, symbol count = 0, SymbolDone = 0, TBStart = 0, TBPage = 0, state = IDLE.
- Reset is asynchronous; asserting it mid-symbol aborts that symbol and discards any pending symbol.
- One-entry holding register {Code, CodeValid}:
  - InReady = ~CodeValid (combinational).
  - Accept edge: Code <= InCode, CodeValid <= 1.
  - Code changes only on accept edges.
- Consume edge: any edge with ACSSegment == all-ones, CodeValid == 1, and either state == IDLE or ACSEnable == 1.
  - On a consume edge: CodeValid <= 0 and the symbol enters the ACS pipeline.
- State IDLE:
  - ACSSegment is held at all-ones and ACSEnable = 0.
  - On a consume edge: go to RUN with ACSSegment <= 0 and ACSEnable <= 1.
- State RUN:
  - ACSSegment increments by 1 per cycle and ACSEnable = 1.
  - At segment all-ones the symbol completes (end edge).
  - If the end edge is also a consume edge: ACSSegment wraps to 0 and RUN continues with no bubble.
  - Otherwise: go to IDLE with ACSEnable <= 0 and ACSSegment held at all-ones.
- Accept coinciding with an end edge while CodeValid = 0: Code updates on that edge, but the branch-metric unit sampled the old, don't-care value. The FSM still goes to IDLE, and the next edge is the consume edge, giving exactly one idle cycle. Accept and consume never occur on the same edge.
- On every end edge:
  - ACSPage <= ACSPage + 1, wrapping modulo 2^WD_PAGE.
  - Symbol count increments, saturating at TB_DEPTH.
  - SymbolDone = 1 for the following cycle.
- TBStart:
  - Asserted for the cycle after an end edge when the post-increment symbol count is >= TB_DEPTH.
  - TBPage is loaded on the end edge with the completing page, the pre-increment ACSPage, and holds until the next end edge.
- Busy = (state == RUN) | CodeValid.
- Sustained throughput: one symbol per 2^WD_FSM cycles when upstream refills within the symbol time.

Test Plan:
- Reset, then a single symbol InCode = 2'b10 accepted at cycle 0 -> consume at cycle 1; ACSEnable high for cycles 2..65 with ACSSegment 0..63; SymbolDone pulse at cycle 66; ACSSegment returns to 3F and is held; ACSPage = 1.
- Back-to-back stream, with each new symbol offered as soon as InReady rises -> ACSSegment wraps 3F to 00 with no idle cycle and ACSEnable stays high; exactly one InReady low interval per symbol.
- Accept timed on the end edge with CodeValid = 0 -> exactly one cycle with ACSEnable = 0 at segment 3F, then RUN restarts at 0.
- TB_DEPTH = 32 with a 40-symbol stream -> the first TBStart follows the 32nd SymbolDone with TBPage = 31; TBStart then follows every later SymbolDone; ACSPage wraps 31 to 0 at symbol 32.
- Reset asserted at segment 0x20 with a symbol pending -> outputs return to reset values immediately (asynchronously); after release, no stale symbol is processed and ACSPage restarts at 0.
- InValid held high while CodeValid = 1 -> InReady = 0; Code is unchanged until the consume edge.
